// File: rtl/uart_tx_control_module.sv
// UART transmit controller: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, each bit held for CLK_FREQ/BAUD clocks.
module uart_tx_control_module #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Tx_En_Sig,
  input  logic [7:0] Tx_Data,
  output logic       Tx_Pin_Out,
  output logic       Tx_Busy_Sig,
  output logic       Tx_Done_Sig
);

  localparam int unsigned BPS_CNT = CLK_FREQ / BAUD;
  localparam int unsigned TMR_W   = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam logic        PAR_EN  = 1'(PARITY_EN);
  localparam logic        PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q, state_nxt;
  logic [TMR_W-1:0]   tmr_q, tmr_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [7:0]         shift_q, shift_nxt;
  logic               par_q, par_nxt;
  logic               pin_nxt, busy_nxt, done_nxt;
  logic               wrap_c;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      Tx_Pin_Out  <= 1'b1;
      Tx_Busy_Sig <= 1'b0;
      Tx_Done_Sig <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      tmr_q       <= tmr_nxt;
      idx_q       <= idx_nxt;
      shift_q     <= shift_nxt;
      par_q       <= par_nxt;
      Tx_Pin_Out  <= pin_nxt;
      Tx_Busy_Sig <= busy_nxt;
      Tx_Done_Sig <= done_nxt;
    end
  end

  // Next-state and next-output logic; line bits change only on timer wrap
  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    pin_nxt   = Tx_Pin_Out;
    busy_nxt  = Tx_Busy_Sig;
    done_nxt  = 1'b0;
    wrap_c    = (tmr_q == TMR_W'(BPS_CNT - 1));

    if (state_q != IDLE) begin
      tmr_nxt = wrap_c ? '0 : tmr_q + TMR_W'(1);
    end

    case (state_q)
      IDLE: begin
        pin_nxt = 1'b1;
        if (Tx_En_Sig) begin
          shift_nxt = Tx_Data;
          par_nxt   = (^Tx_Data) ^ PAR_ODD;
          state_nxt = START;
          pin_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          tmr_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      START: begin
        if (wrap_c) begin
          pin_nxt   = shift_q[0];
          shift_nxt = {1'b0, shift_q[7:1]};
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (wrap_c) begin
          if (idx_q == IDX_W'(7)) begin
            idx_nxt = '0;
            if (PAR_EN) begin
              state_nxt = PARITY;
              pin_nxt   = par_q;
            end else begin
              state_nxt = STOP;
              pin_nxt   = 1'b1;
            end
          end else begin
            pin_nxt   = shift_q[0];
            shift_nxt = {1'b0, shift_q[7:1]};
            idx_nxt   = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (wrap_c) begin
          state_nxt = STOP;
          pin_nxt   = 1'b1;
          idx_nxt   = '0;
        end
      end
      STOP: begin
        // idx_q counts completed stop-bit periods
        if (wrap_c) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_control_module.sv
// Bench for uart_tx_control_module: four parameter sets, a frame-timing model
// feeding a scoreboard, and a line receiver that decodes and checks each frame.
`timescale 1ns/1ps
module tb_uart_tx_control_module;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned e0;
  } exp_t;

  task automatic chk(input int g, input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               g, name, act, act, exp, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_cfg
    localparam int unsigned CF  = (g == 3) ? 50000000 : 1000000;
    localparam int unsigned BD  = (g == 3) ? 9600 : 100000;
    localparam int unsigned PEN = (g == 1 || g == 2) ? 1 : 0;
    localparam int unsigned POD = (g == 2) ? 1 : 0;
    localparam int unsigned SB  = (g == 1 || g == 2) ? 2 : 1;
    localparam int unsigned B   = CF / BD;
    localparam int unsigned NB  = 1 + 8 + PEN + SB;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       pin, busy, done;
    bit         fin = 1'b0;

    uart_tx_control_module #(
      .CLK_FREQ  (CF),
      .BAUD      (BD),
      .PARITY_EN (PEN),
      .PARITY_ODD(POD),
      .STOP_BITS (SB)
    ) dut (
      .CLK        (CLK),
      .RST        (rst),
      .Tx_En_Sig  (en),
      .Tx_Data    (dat),
      .Tx_Pin_Out (pin),
      .Tx_Busy_Sig(busy),
      .Tx_Done_Sig(done)
    );

    // Reference model: a request is accepted when the line is free; a frame
    // lasts NB*B clocks and the next request can land one clock after done.
    exp_t        q[$];
    int unsigned next_free = 0;
    int unsigned mk;
    bit          rst_seen = 1'b1;

    always @(posedge CLK) begin
      mk = cyc + 1;
      rst_seen = rst;
      if (rst) begin
        q.delete();
        next_free = mk + 1;
      end else if (en && mk >= next_free) begin
        q.push_back('{dat, mk});
        next_free = mk + NB * B + 1;
      end
    end

    // Line receiver and scoreboard checker
    bit          rx_act = 1'b0;
    int unsigned rx_start = 0;
    int unsigned busy_cnt = 0;
    int unsigned glitch = 0;
    int unsigned off, bi, ones;
    logic        rx_bits [16];
    logic        cur_lvl = 1'b1;
    logic [7:0]  rxd;
    exp_t        ex;
    int          exp_b9;

    always @(negedge CLK) begin
      if (rst_seen) begin
        chk(g, "reset_outputs", {pin === 1'b1, busy === 1'b0, done === 1'b0}, 3'b111);
        rx_act   = 1'b0;
        busy_cnt = 0;
        glitch   = 0;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (!rx_act && pin === 1'b0) begin
          chk(g, "frame_expected", int'(q.size() != 0), 1);
          rx_act   = 1'b1;
          rx_start = cyc;
          glitch   = 0;
        end
        if (rx_act) begin
          off = cyc - rx_start;
          bi  = off / B;
          if (off % B == 0) begin
            cur_lvl     = pin;
            rx_bits[bi] = pin;
          end else if (pin !== cur_lvl) begin
            glitch++;
          end
          if (off == NB * B - 1) rx_act = 1'b0;
        end
        if (done === 1'b1) begin
          chk(g, "done_has_frame", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            ex = q.pop_front();
            for (int i = 0; i < 8; i++) rxd[i] = rx_bits[i + 1];
            exp_b9 = (PEN != 0) ? int'(($countones(ex.data) + POD) % 2) : 1;
            ones = 0;
            for (int i = 9 + int'(PEN); i < int'(NB); i++) ones += int'(rx_bits[i] === 1'b1);
            chk(g, "start_edge", rx_start, ex.e0);
            chk(g, "done_edge", cyc, ex.e0 + NB * B);
            chk(g, "start_bit", rx_bits[0], 0);
            chk(g, "data", rxd, ex.data);
            chk(g, "bit9", rx_bits[9], exp_b9);
            chk(g, "stop_ones", ones, SB);
            chk(g, "busy_len", busy_cnt, NB * B);
            chk(g, "glitches", glitch, 0);
          end
          busy_cnt = 0;
        end
      end
    end

    task automatic pulse(input logic [7:0] d);
      @(posedge CLK); #1;
      en  = 1'b1;
      dat = d;
      @(posedge CLK); #1;
      en  = 1'b0;
    endtask

    task automatic drain();
      int unsigned t;
      en = 1'b0;
      t  = 0;
      while ((q.size() != 0 || rx_act) && t < 60000) begin
        @(negedge CLK);
        t++;
      end
      repeat (3) @(negedge CLK);
      chk(g, "drain_empty", q.size(), 0);
      fin = 1'b1;
    endtask

    if (g == 0) begin : gen_stim0
      logic [9:0] pat;
      initial begin
        pat = 10'b1101001010;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge CLK);
          chk(g, "idle", {pin, busy, done}, 3'b100);
        end
        // Single A5 frame, line sampled mid-bit against the literal pattern
        pulse(8'hA5);
        @(negedge CLK);
        repeat (B / 2) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
          chk(g, "a5_line_bit", pin, pat[i]);
          repeat (B) @(negedge CLK);
        end
        repeat (10) @(negedge CLK);
        // Held request, data changed during the first frame
        @(posedge CLK); #1;
        en  = 1'b1;
        dat = 8'h3C;
        repeat (50) @(posedge CLK);
        #1 dat = 8'hC3;
        repeat (100) @(posedge CLK);
        #1 en = 1'b0;
        repeat (80) @(posedge CLK);
        // Random requests, many landing while busy
        for (int i = 0; i < 3000; i++) begin
          @(posedge CLK); #1;
          en  = ($urandom_range(0, 19) == 0);
          dat = 8'($urandom);
        end
        #0 en = 1'b0;
        repeat (120) @(posedge CLK);
        // Reset during D3 (line bit 4)
        pulse(8'h96);
        repeat (43) @(posedge CLK);
        #1 rst = 1'b1;
        @(posedge CLK);
        #1 rst = 1'b0;
        repeat (20) @(posedge CLK);
        pulse(8'h69);
        repeat (NB * B + 10) @(posedge CLK);
        drain();
      end
    end else if (g == 1 || g == 2) begin : gen_stim12
      localparam int unsigned EXP_P = (POD != 0) ? 0 : 1;
      initial begin
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        repeat (5) @(posedge CLK);
        pulse(8'h07);
        @(negedge CLK);
        repeat (B / 2 + 9 * B) @(negedge CLK);
        chk(g, "parity_07", pin, EXP_P);
        repeat (B) @(negedge CLK);
        chk(g, "stop1", pin, 1);
        repeat (B) @(negedge CLK);
        chk(g, "stop2", pin, 1);
        repeat (10) @(negedge CLK);
        for (int i = 0; i < 1500; i++) begin
          @(posedge CLK); #1;
          en  = ($urandom_range(0, 24) == 0);
          dat = 8'($urandom);
        end
        drain();
      end
    end else begin : gen_stim3
      initial begin
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        repeat (5) @(posedge CLK);
        pulse(8'h55);
        repeat (NB * B + 10) @(posedge CLK);
        drain();
      end
    end
  end

  initial begin
    int unsigned t;
    t = 0;
    while (!(gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin && gen_cfg[3].fin)
           && t < 90000) begin
      @(posedge CLK);
      t++;
    end
    chk(-1, "all_configs_finished",
        int'(gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin && gen_cfg[3].fin), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
